// File: rtl/sao_pkg.sv
// Shared definitions for the SAO edge-offset statistics path:
// category codes, accumulator width helpers and the accumulator FSM states.
package sao_pkg;

  localparam int SAO_EO_NONE    = 0;
  localparam int SAO_EO_VALLEY  = 1;
  localparam int SAO_EO_CONCAVE = 2;
  localparam int SAO_EO_CONVEX  = 3;
  localparam int SAO_EO_PEAK    = 4;
  localparam int SAO_EO_NUM_CAT = 4;

  // Count width holds 2^(2*ctb_log2) samples without overflow.
  function automatic int sao_cnt_width(input int ctb_log2);
    return 2 * ctb_log2 + 1;
  endfunction

  function automatic int sao_sum_width(input int bit_depth, input int ctb_log2);
    return bit_depth + 1 + 2 * ctb_log2;
  endfunction

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } sao_state_e;

endpackage

// File: rtl/sao_eo_lane_reduce.sv
// Combinational per-category reduction of one beat: how many enabled lanes
// carry category CAT, and the signed sum of their diffs.
module sao_eo_lane_reduce #(
  parameter  int bit_depth = 8,
  parameter  int NUM_PIX   = 4,
  parameter  int CAT       = 1,
  localparam int DW        = bit_depth + 1,
  localparam int HW        = $clog2(NUM_PIX) + 1,
  localparam int RW        = DW + $clog2(NUM_PIX)
) (
  input  logic [NUM_PIX*3-1:0]  cat,
  input  logic [NUM_PIX*DW-1:0] diff,
  input  logic [NUM_PIX-1:0]    mask,
  output logic [HW-1:0]         hit_cnt,
  output logic signed [RW-1:0]  hit_sum
);

  always_comb begin
    hit_cnt = '0;
    hit_sum = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      if (mask[i] && (cat[3*i +: 3] == 3'(CAT))) begin
        hit_cnt = hit_cnt + HW'(1);
        hit_sum = hit_sum + RW'($signed(diff[DW*i +: DW]));
      end
    end
  end

endmodule

// File: rtl/sao_eo_stat_accum.sv
// Per-CTB accumulation of EO category counts and diff sums, handed to the
// offset-decision stage through a valid/ready register stage.
module sao_eo_stat_accum
  import sao_pkg::*;
#(
  parameter  int bit_depth = 8,
  parameter  int NUM_PIX   = 4,
  parameter  int CTB_LOG2  = 6,
  localparam int DW        = bit_depth + 1,
  localparam int CW        = sao_cnt_width(CTB_LOG2),
  localparam int SW        = sao_sum_width(bit_depth, CTB_LOG2)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_PIX*3-1:0]  in_cat,
  input  logic [NUM_PIX*DW-1:0] in_diff,
  input  logic [NUM_PIX-1:0]    in_mask,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*CW-1:0]       out_cnt,
  output logic [4*SW-1:0]       out_sum,
  output logic                  err
);

  localparam int HW = $clog2(NUM_PIX) + 1;
  localparam int RW = DW + $clog2(NUM_PIX);

  sao_state_e state, state_nxt;
  logic accept;
  logic bad_cat;

  logic [HW-1:0]        hit_cnt [SAO_EO_NUM_CAT];
  logic signed [RW-1:0] hit_sum [SAO_EO_NUM_CAT];
  logic [CW-1:0]        acc_cnt [SAO_EO_NUM_CAT];
  logic signed [SW-1:0] acc_sum [SAO_EO_NUM_CAT];
  logic [CW-1:0]        tot_cnt [SAO_EO_NUM_CAT];
  logic signed [SW-1:0] tot_sum [SAO_EO_NUM_CAT];

  assign accept = in_valid && in_ready;

  for (genvar k = 0; k < SAO_EO_NUM_CAT; k++) begin : g_reduce
    sao_eo_lane_reduce #(
      .bit_depth(bit_depth),
      .NUM_PIX  (NUM_PIX),
      .CAT      (SAO_EO_VALLEY + k)
    ) u_reduce (
      .cat    (in_cat),
      .diff   (in_diff),
      .mask   (in_mask),
      .hit_cnt(hit_cnt[k]),
      .hit_sum(hit_sum[k])
    );
  end

  // Running totals including the current beat; wrap naturally past a full CTB.
  always_comb begin
    for (int k = 0; k < SAO_EO_NUM_CAT; k++) begin
      tot_cnt[k] = acc_cnt[k] + CW'(hit_cnt[k]);
      tot_sum[k] = acc_sum[k] + SW'(hit_sum[k]);
    end
  end

  always_comb begin
    bad_cat = 1'b0;
    for (int i = 0; i < NUM_PIX; i++) begin
      if (in_mask[i] && (in_cat[3*i +: 3] > 3'(SAO_EO_PEAK))) begin
        bad_cat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACC;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:     if (accept && in_last) state_nxt = HOLD;
      HOLD:    if (out_ready)         state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_comb begin
    in_ready  = (state == ACC);
    out_valid = (state == HOLD);
  end

  // The closing beat publishes its totals and restarts accumulation in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SAO_EO_NUM_CAT; k++) begin
        acc_cnt[k] <= '0;
        acc_sum[k] <= '0;
      end
      out_cnt <= '0;
      out_sum <= '0;
      err     <= 1'b0;
    end else if (accept) begin
      if (bad_cat) begin
        err <= 1'b1;
      end
      for (int k = 0; k < SAO_EO_NUM_CAT; k++) begin
        if (in_last) begin
          acc_cnt[k]            <= '0;
          acc_sum[k]            <= '0;
          out_cnt[k*CW +: CW]   <= tot_cnt[k];
          out_sum[k*SW +: SW]   <= tot_sum[k];
        end else begin
          acc_cnt[k] <= tot_cnt[k];
          acc_sum[k] <= tot_sum[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_sao_eo_stat_accum.sv
// Randomized bench for sao_eo_stat_accum against a cycle-level model built
// from per-lane integer arithmetic on the decoded stimulus.
module tb_sao_eo_stat_accum;

  localparam int BD = 8;
  localparam int NP = 4;
  localparam int CL = 6;
  localparam int DW = BD + 1;
  localparam int CW = 2 * CL + 1;
  localparam int SW = BD + 1 + 2 * CL;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [NP*3-1:0]   in_cat;
  logic [NP*DW-1:0]  in_diff;
  logic [NP-1:0]     in_mask;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [4*CW-1:0]   out_cnt;
  logic [4*SW-1:0]   out_sum;
  logic              err;

  int     check_count = 0;
  int     fail_count  = 0;
  int     acc_cnt [4];
  longint acc_sum [4];
  int     exp_cnt [4];
  longint exp_sum [4];
  bit     m_hold;
  bit     m_err;

  always #5 clk = ~clk;

  sao_eo_stat_accum #(
    .bit_depth(BD),
    .NUM_PIX  (NP),
    .CTB_LOG2 (CL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_cat   (in_cat),
    .in_diff  (in_diff),
    .in_mask  (in_mask),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cnt  (out_cnt),
    .out_sum  (out_sum),
    .err      (err)
  );

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [NP*3-1:0] pack_cat(input int c0, input int c1, input int c2, input int c3);
    logic [NP*3-1:0] v;
    v = {3'(c3), 3'(c2), 3'(c1), 3'(c0)};
    return v;
  endfunction

  function automatic logic [NP*DW-1:0] pack_diff(input int d0, input int d1, input int d2, input int d3);
    logic [NP*DW-1:0] v;
    v = {9'(d3), 9'(d2), 9'(d1), 9'(d0)};
    return v;
  endfunction

  task automatic modelClear();
    for (int k = 0; k < 4; k++) begin
      acc_cnt[k] = 0;
      acc_sum[k] = 0;
      exp_cnt[k] = 0;
      exp_sum[k] = 0;
    end
    m_hold = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic checkState();
    logic [4*CW-1:0] ec;
    logic [4*SW-1:0] es;
    for (int k = 0; k < 4; k++) begin
      ec[k*CW +: CW] = CW'(exp_cnt[k]);
      es[k*SW +: SW] = SW'(exp_sum[k]);
    end
    checkOutput("in_ready",  128'(in_ready),  128'(!m_hold));
    checkOutput("out_valid", 128'(out_valid), 128'(m_hold));
    checkOutput("err",       128'(err),       128'(m_err));
    checkOutput("out_cnt",   128'(out_cnt),   128'(ec));
    checkOutput("out_sum",   128'(out_sum),   128'(es));
  endtask

  // One clock of stimulus; the model predicts the state after the coming edge.
  task automatic applyStimulus(input bit v, input logic [NP*3-1:0] c, input logic [NP*DW-1:0] d,
                               input logic [NP-1:0] m, input bit last, input bit ordy);
    int ci;
    int di;
    @(negedge clk);
    checkState();
    rst       = 1'b0;
    in_valid  = v;
    in_cat    = c;
    in_diff   = d;
    in_mask   = m;
    in_last   = last;
    out_ready = ordy;
    if (m_hold) begin
      if (ordy) m_hold = 1'b0;
    end else if (v) begin
      for (int i = 0; i < NP; i++) begin
        ci = int'(c[3*i +: 3]);
        di = int'($signed(d[DW*i +: DW]));
        if (m[i]) begin
          if (ci >= 1 && ci <= 4) begin
            acc_cnt[ci-1] += 1;
            acc_sum[ci-1] += di;
          end else if (ci >= 5) begin
            m_err = 1'b1;
          end
        end
      end
      if (last) begin
        for (int k = 0; k < 4; k++) begin
          exp_cnt[k] = acc_cnt[k];
          exp_sum[k] = acc_sum[k];
          acc_cnt[k] = 0;
          acc_sum[k] = 0;
        end
        m_hold = 1'b1;
      end
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    checkState();
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_last   = 1'b1;
    in_mask   = '1;
    in_cat    = pack_cat(1, 2, 3, 6);
    in_diff   = pack_diff(7, 7, 7, 7);
    out_ready = 1'b1;
    modelClear();
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, '0, '0, 1'b0, ordy);
  endtask

  task automatic randomBeat(input bit v, input bit last, input bit ordy, input int maxcat);
    logic [NP*3-1:0]  c;
    logic [NP*DW-1:0] d;
    for (int i = 0; i < NP; i++) begin
      c[3*i +: 3]   = 3'($urandom_range(0, maxcat));
      d[DW*i +: DW] = 9'(int'($urandom_range(0, 510)) - 255);
    end
    applyStimulus(v, c, d, 4'($urandom), last, ordy);
  endtask

  // Explicit totals at the negedge after a closing beat issued with out_ready=0.
  task automatic peekTotals(input string tag, input int ec[4], input longint es[4], input bit eerr);
    logic [CW-1:0] cv;
    logic [SW-1:0] sv;
    @(negedge clk);
    checkOutput({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
    checkOutput({tag, "_err"},   128'(err),       128'(eerr));
    for (int k = 0; k < 4; k++) begin
      cv = CW'(ec[k]);
      sv = SW'(es[k]);
      checkOutput($sformatf("%s_cnt%0d", tag, k + 1), 128'(out_cnt[k*CW +: CW]), 128'(cv));
      checkOutput($sformatf("%s_sum%0d", tag, k + 1), 128'(out_sum[k*SW +: SW]), 128'(sv));
    end
  endtask

  initial begin
    int nbeats;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_cat    = '0;
    in_diff   = '0;
    in_mask   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    modelClear();

    idle(2, 1'b0);

    // one beat, each category once
    applyStimulus(1'b1, pack_cat(1, 2, 3, 4), pack_diff(5, -3, 7, -1), 4'hf, 1'b1, 1'b0);
    peekTotals("single", '{1, 1, 1, 1}, '{5, -3, 7, -1}, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b1);

    // duplicate categories across lanes
    for (int b = 0; b < 3; b++)
      applyStimulus(1'b1, pack_cat(2, 2, 2, 2), pack_diff(2, 2, 2, 2), 4'hf, b == 2, 1'b0);
    peekTotals("dup", '{0, 12, 0, 0}, '{0, 24, 0, 0}, 1'b0);
    idle(1, 1'b1);

    // masked lane, category 0 and an illegal category
    applyStimulus(1'b1, pack_cat(0, 6, 3, 3), pack_diff(9, 9, -4, -4), 4'b1011, 1'b1, 1'b0);
    peekTotals("illegal", '{0, 0, 1, 0}, '{0, 0, -4, 0}, 1'b1);
    idle(1, 1'b1);

    // backpressure: beats offered during HOLD must be dropped
    for (int b = 0; b < 3; b++) randomBeat(1'b1, b == 2, 1'b0, 4);
    for (int b = 0; b < 5; b++) randomBeat(1'b1, 1'($urandom), 1'b0, 7);
    idle(1, 1'b1);
    for (int b = 0; b < 2; b++) randomBeat(1'b1, b == 1, 1'b0, 4);
    idle(2, 1'b0);
    idle(1, 1'b1);

    // full CTB at the most negative diff
    for (int b = 0; b < 1024; b++)
      applyStimulus(1'b1, pack_cat(4, 4, 4, 4), pack_diff(-255, -255, -255, -255), 4'hf, b == 1023, 1'b0);
    peekTotals("full", '{0, 0, 0, 4096}, '{0, 0, 0, -1044480}, 1'b1);
    idle(1, 1'b1);

    // closing beat with no enabled lanes
    applyStimulus(1'b1, pack_cat(1, 2, 3, 4), pack_diff(1, 1, 1, 1), 4'b0000, 1'b1, 1'b0);
    peekTotals("empty", '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1'b1);
    idle(1, 1'b1);

    // reset in the middle of a CTB
    for (int b = 0; b < 10; b++) randomBeat(1'b1, 1'b0, 1'b0, 4);
    applyReset();
    applyStimulus(1'b1, pack_cat(1, 0, 0, 0), pack_diff(1, 0, 0, 0), 4'b0001, 1'b1, 1'b0);
    peekTotals("rstmid", '{1, 0, 0, 0}, '{1, 0, 0, 0}, 1'b0);
    idle(1, 1'b1);

    // random CTBs with random gaps and consumer stalls
    for (int t = 0; t < 25; t++) begin
      nbeats = $urandom_range(1, 20);
      for (int b = 0; b < nbeats; b++) begin
        if (b == nbeats - 1) randomBeat(1'b1, 1'b1, 1'b0, (t < 20) ? 4 : 7);
        else                 randomBeat(($urandom_range(0, 3) != 0), 1'b0, 1'($urandom), (t < 20) ? 4 : 7);
      end
      for (int s = 0; s < int'($urandom_range(0, 3)); s++) randomBeat(1'b1, 1'b1, 1'b0, 7);
      idle(1, 1'b1);
    end
    idle(2, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
